tm1638_key_reader: RTL and testbench
====================================

Name: tm1638_key_reader

Overview:
- Reads the TM1638 key-scan matrix over the same 3-wire bus (stb, sclk, dio) that the display writer drives.
- On each start request it sends the read-keys command 0x42, turns the bus around and clocks in the 4 key-scan bytes.
- Decodes the bytes into 8 key bits and flags newly pressed keys.
- The top level muxes stb/sclk/dio between this block and the display writer. This block only runs when the writer is idle, which the top level guarantees.

Parameters:
- CLK_DIV, 25, clk_50M cycles per sclk half-period (25 gives 1 MHz sclk). Minimum 2.
- WAIT_CYCLES, 100, clk_50M cycles of bus turnaround between the command and the read phase (TM1638 needs ≥1 us). Minimum 1.

Ports:
- clk_50M  in  1  system clock, 50 MHz
- RST  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to perform one key read
- busy  out  1  high while a transaction is in progress
- valid  out  1  one-cycle pulse when raw_keys/keys/key_press are updated
- stb  out  1  TM1638 strobe, active low, idle high
- sclk  out  1  TM1638 serial clock, idle high
- dio_out  out  1  serial data driven to TM1638
- dio_oe  out  1  1 = drive dio_out onto the pad, 0 = release the pad
- dio_in  in  1  pad value of dio (already synchronised by the top level)
- raw_keys  out  32  {byte3, byte2, byte1, byte0}, as received
- keys  out  8  keys[i] = byte i bit0 and keys[i+4] = byte i bit4, for i = 0..3
- key_press  out  8  keys & ~previous keys, updated together with keys

Behaviour:
- Reset (RST low, asynchronous):
  - state = IDLE; stb = 1, sclk = 1, dio_out = 1, dio_oe = 0.
  - busy = 0, valid = 0; raw_keys, keys and key_press = 0; previous-keys register = 0.
  - Reset mid-transaction aborts immediately to these values. No partial results are latched.
- Phase timing: a divider counts CLK_DIV cycles per phase. Bits are sent and received LSB first.
- IDLE:
  - start = 1 → STB_SETUP. busy goes 1 on the next edge.
  - start while busy = 1 is ignored.
- STB_SETUP: stb = 0, dio_oe = 1, sclk = 1, for CLK_DIV cycles → CMD.
- CMD: 8 bits of 0x42. Per bit:
  - Low phase: sclk = 0, dio_out = bit, for CLK_DIV cycles.
  - High phase: sclk = 1, for CLK_DIV cycles.
  - After bit 7's high phase → WAIT.
- WAIT: dio_oe = 0, sclk = 1, stb = 0, for WAIT_CYCLES cycles → READ.
- READ: 32 bits. Per bit:
  - Low phase: sclk = 0, CLK_DIV cycles.
  - High phase: sclk = 1, CLK_DIV cycles.
  - dio_in is sampled into the shift register in the same cycle sclk goes 0→1.
  - Bit k lands in raw shift bit k.
  - After bit 31's high phase → STB_HOLD.
- STB_HOLD: stb = 1, sclk = 1, dio_oe = 0, for CLK_DIV cycles → DONE.
- DONE (one cycle):
  - raw_keys ← shift register; keys ← decode of the shift register.
  - key_press ← decoded keys & ~previous keys; previous keys ← decoded keys.
  - valid = 1 for this cycle only.
  - Next edge → IDLE with busy = 0.
- Latency: valid is high exactly 82·CLK_DIV + WAIT_CYCLES + 1 cycles after the edge that samples start (2151 cycles with the defaults).
- start asserted in the same cycle as valid is ignored. A new start is accepted from IDLE on the following cycle.
- dio_oe is never 1 during WAIT or READ, so there is no bus contention with the TM1638.
- Outputs hold their last values between transactions.

Test Plan:
- Reset: hold RST low for 5 cycles, then release → stb = 1, sclk = 1, dio_oe = 0, busy = 0, valid = 0, raw_keys = 0, keys = 0, key_press = 0.
- Command phase: pulse start; monitor dio_out at each sclk rising edge while dio_oe = 1 → sequence 0,1,0,0,0,0,1,0 (0x42), with stb low throughout and exactly 8 sclk rises before dio_oe drops.
- Read with TM1638 model returning 0x01, 0x10, 0x00, 0x11 (model changes dio on sclk falling edges) → raw_keys = 0x11001001, keys = 0xA9, key_press = 0xA9, valid one cycle at cycle 2151 after start.
- Second read with identical bytes → keys = 0xA9, key_press = 0x00. Third read with all-zero bytes → keys = 0x00, key_press = 0x00.
- start pulses during busy (in CMD, WAIT and READ) → ignored: still exactly 40 sclk rises and one valid pulse per transaction.
- RST low in the middle of READ (bit 15) → immediate idle values, no valid pulse. A fresh start then completes normally with correct data.

Source files
------------

// File: rtl/tm1638_key_reader.sv
// TM1638 key-scan reader: sends the read-keys command, releases dio,
// clocks in four key-scan bytes LSB first and decodes them into 8 keys.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | bus idle (stb/sclk high, dio released), waiting for start
// STB_SETUP| stb low, dio driven, one phase before the first clock
// CMD      | shifting out 0x42, low phase drives bit, high phase holds
// WAIT     | dio released, turnaround time before the chip drives dio
// READ     | 32 clocks, dio_in captured on each sclk rising edge
// STB_HOLD | stb back high for one phase
// DONE     | results latched and valid pulsed on leaving this state
module tm1638_key_reader #(
  parameter int CLK_DIV     = 25,
  parameter int WAIT_CYCLES = 100
) (
  input  logic        clk_50M,
  input  logic        RST,
  input  logic        start,
  output logic        busy,
  output logic        valid,
  output logic        stb,
  output logic        sclk,
  output logic        dio_out,
  output logic        dio_oe,
  input  logic        dio_in,
  output logic [31:0] raw_keys,
  output logic [7:0]  keys,
  output logic [7:0]  key_press
);

  localparam int MAX_CNT = (CLK_DIV > WAIT_CYCLES) ? CLK_DIV : WAIT_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES - 1);
  localparam logic [7:0]    CMD_READ  = 8'h42;

  typedef enum logic [2:0] {
    IDLE, STB_SETUP, CMD, WAIT, READ, STB_HOLD, DONE
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  div_q;
  logic [4:0]     bit_q;
  logic           high_q;
  logic [31:0]    shift_q;
  logic [7:0]     prev_keys_q;
  logic           busy_q, valid_q, stb_q, sclk_q, dio_out_q, dio_oe_q;
  logic [31:0]    raw_keys_q;
  logic [7:0]     keys_q, key_press_q;
  logic [7:0]     keys_dec_d;

  // Key bits live in bit0 and bit4 of each scan byte.
  always_comb begin
    keys_dec_d = '0;
    for (int i = 0; i < 4; i++) begin
      keys_dec_d[i]     = shift_q[8*i];
      keys_dec_d[i + 4] = shift_q[8*i + 4];
    end
  end

  // Sequencer: all bus pins and results are registered here.
  always_ff @(posedge clk_50M or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      high_q      <= 1'b0;
      shift_q     <= '0;
      prev_keys_q <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      stb_q       <= 1'b1;
      sclk_q      <= 1'b1;
      dio_out_q   <= 1'b1;
      dio_oe_q    <= 1'b0;
      raw_keys_q  <= '0;
      keys_q      <= '0;
      key_press_q <= '0;
    end else begin
      valid_q <= 1'b0;
      if (state_q != IDLE && div_q != '0)
        div_q <= div_q - 1'b1;
      case (state_q)
        IDLE: begin
          // valid_q marks the cycle right after DONE; a start there is dropped
          if (start && !valid_q) begin
            state_q   <= STB_SETUP;
            busy_q    <= 1'b1;
            stb_q     <= 1'b0;
            sclk_q    <= 1'b1;
            dio_oe_q  <= 1'b1;
            dio_out_q <= 1'b1;
            shift_q   <= '0;
            div_q     <= DIV_LOAD;
          end
        end
        STB_SETUP: begin
          if (div_q == '0) begin
            state_q   <= CMD;
            bit_q     <= '0;
            high_q    <= 1'b0;
            sclk_q    <= 1'b0;
            dio_out_q <= CMD_READ[0];
            div_q     <= DIV_LOAD;
          end
        end
        CMD: begin
          if (div_q == '0) begin
            if (!high_q) begin
              high_q <= 1'b1;
              sclk_q <= 1'b1;
              div_q  <= DIV_LOAD;
            end else if (bit_q == 5'd7) begin
              state_q  <= WAIT;
              dio_oe_q <= 1'b0;
              div_q    <= WAIT_LOAD;
            end else begin
              bit_q     <= bit_q + 1'b1;
              high_q    <= 1'b0;
              sclk_q    <= 1'b0;
              dio_out_q <= CMD_READ[bit_q[2:0] + 3'd1];
              div_q     <= DIV_LOAD;
            end
          end
        end
        WAIT: begin
          if (div_q == '0) begin
            state_q <= READ;
            bit_q   <= '0;
            high_q  <= 1'b0;
            sclk_q  <= 1'b0;
            div_q   <= DIV_LOAD;
          end
        end
        READ: begin
          if (div_q == '0) begin
            if (!high_q) begin
              high_q         <= 1'b1;
              sclk_q         <= 1'b1;
              shift_q[bit_q] <= dio_in;
              div_q          <= DIV_LOAD;
            end else if (bit_q == 5'd31) begin
              state_q <= STB_HOLD;
              stb_q   <= 1'b1;
              div_q   <= DIV_LOAD;
            end else begin
              bit_q  <= bit_q + 1'b1;
              high_q <= 1'b0;
              sclk_q <= 1'b0;
              div_q  <= DIV_LOAD;
            end
          end
        end
        STB_HOLD: begin
          if (div_q == '0)
            state_q <= DONE;
        end
        DONE: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          valid_q     <= 1'b1;
          raw_keys_q  <= shift_q;
          keys_q      <= keys_dec_d;
          key_press_q <= keys_dec_d & ~prev_keys_q;
          prev_keys_q <= keys_dec_d;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign valid     = valid_q;
  assign stb       = stb_q;
  assign sclk      = sclk_q;
  assign dio_out   = dio_out_q;
  assign dio_oe    = dio_oe_q;
  assign raw_keys  = raw_keys_q;
  assign keys      = keys_q;
  assign key_press = key_press_q;

endmodule

// File: tb/tb_tm1638_key_reader.sv
// Directed bench for tm1638_key_reader with a simple TM1638 read-side model.
module tb_tm1638_key_reader;

  logic        clk_50M = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic        busy, valid, stb, sclk, dio_out, dio_oe;
  logic        dio_in = 1'b1;
  logic [31:0] raw_keys;
  logic [7:0]  keys, key_press;

  int checks = 0;
  int errors = 0;

  tm1638_key_reader #(.CLK_DIV(25), .WAIT_CYCLES(100)) dut (
    .clk_50M(clk_50M), .RST(RST), .start(start), .busy(busy), .valid(valid),
    .stb(stb), .sclk(sclk), .dio_out(dio_out), .dio_oe(dio_oe), .dio_in(dio_in),
    .raw_keys(raw_keys), .keys(keys), .key_press(key_press)
  );

  always #10 clk_50M = ~clk_50M;

  // TM1638 model: presents the next read bit on each sclk falling edge.
  logic [31:0] model_data = '0;
  int          rd_idx = 0;
  always @(negedge sclk) begin
    if (dio_oe) rd_idx = 0;
    else if (!stb && rd_idx < 32) begin
      dio_in = model_data[rd_idx];
      rd_idx++;
    end
  end

  // Bus monitors: free-running counts, the stimulus takes snapshots.
  int          rise_cnt = 0, cmd_cnt = 0, cmd_stb_bad = 0, valid_cnt = 0;
  logic [7:0]  cmd_shift = '0;
  always @(posedge sclk) begin
    if (!stb) rise_cnt++;
    if (dio_oe) begin
      cmd_shift = {dio_out, cmd_shift[7:1]};
      cmd_cnt++;
      if (stb) cmd_stb_bad++;
    end
  end
  always @(posedge clk_50M) if (valid) valid_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction; optional start pulses while busy and in the valid cycle.
  task automatic do_txn(input logic [31:0] data, input bit noise, output int lat);
    int r0, c0, v0;
    model_data = data;
    r0 = rise_cnt; c0 = cmd_cnt; v0 = valid_cnt;
    @(negedge clk_50M); start = 1'b1;
    @(negedge clk_50M); start = 1'b0;
    lat = 0;
    while (lat < 5000) begin
      @(posedge clk_50M); #1;
      lat++;
      if (valid) break;
      start = noise && (lat == 100 || lat == 480 || lat == 1000);
    end
    if (noise) begin
      start = 1'b1;                       // start in the valid cycle
      @(posedge clk_50M); #1;
      start = 1'b0;
      check("start_in_valid_ignored", {31'd0, busy}, 32'd0);
    end else begin
      @(posedge clk_50M); #1;
    end
    check("valid_one_cycle", {31'd0, valid}, 32'd0);
    repeat (5) @(posedge clk_50M);
    #1;
    check("sclk_rises", rise_cnt - r0, 32'd40);
    check("cmd_rises", cmd_cnt - c0, 32'd8);
    check("valid_pulses", valid_cnt - v0, 32'd1);
    check("busy_after", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    int v0;

    // Reset
    repeat (5) @(negedge clk_50M);
    RST = 1'b1;
    @(posedge clk_50M); #1;
    check("rst_stb", {31'd0, stb}, 32'd1);
    check("rst_sclk", {31'd0, sclk}, 32'd1);
    check("rst_dio_oe", {31'd0, dio_oe}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_raw", raw_keys, 32'd0);
    check("rst_keys", {24'd0, keys}, 32'd0);
    check("rst_press", {24'd0, key_press}, 32'd0);

    // First read: bytes 0x01, 0x10, 0x00, 0x11
    do_txn(32'h1100_1001, 1'b0, lat);
    check("latency", lat, 32'd2151);
    check("cmd_byte", {24'd0, cmd_shift}, 32'h42);
    check("cmd_stb_low", cmd_stb_bad, 32'd0);
    check("raw1", raw_keys, 32'h1100_1001);
    check("keys1", {24'd0, keys}, 32'hA9);
    check("press1", {24'd0, key_press}, 32'hA9);

    // Second read, same bytes, with start pulses in CMD/WAIT/READ
    do_txn(32'h1100_1001, 1'b1, lat);
    check("latency2", lat, 32'd2151);
    check("keys2", {24'd0, keys}, 32'hA9);
    check("press2", {24'd0, key_press}, 32'h00);

    // Third read, all zero
    do_txn(32'h0000_0000, 1'b0, lat);
    check("raw3", raw_keys, 32'd0);
    check("keys3", {24'd0, keys}, 32'h00);
    check("press3", {24'd0, key_press}, 32'h00);

    // Reset during READ bit 15, after a read that leaves keys nonzero
    do_txn(32'h0000_0011, 1'b0, lat);
    check("keys4", {24'd0, keys}, 32'h11);
    model_data = 32'hFFFF_FFFF;
    v0 = valid_cnt;
    @(negedge clk_50M); start = 1'b1;
    @(negedge clk_50M); start = 1'b0;
    repeat (1285) @(posedge clk_50M);
    #1;
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    check("abort_sclk_low", {31'd0, sclk}, 32'd0);
    RST = 1'b0;
    #1;
    check("abort_stb", {31'd0, stb}, 32'd1);
    check("abort_sclk", {31'd0, sclk}, 32'd1);
    check("abort_dio_oe", {31'd0, dio_oe}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_raw", raw_keys, 32'd0);
    check("abort_keys", {24'd0, keys}, 32'd0);
    repeat (3) @(negedge clk_50M);
    RST = 1'b1;
    repeat (2300) @(posedge clk_50M);
    #1;
    check("abort_no_valid", valid_cnt - v0, 32'd0);
    check("abort_idle_busy", {31'd0, busy}, 32'd0);

    // Fresh read after abort: previous keys were cleared by reset
    do_txn(32'h1100_1001, 1'b0, lat);
    check("latency5", lat, 32'd2151);
    check("raw5", raw_keys, 32'h1100_1001);
    check("keys5", {24'd0, keys}, 32'hA9);
    check("press5", {24'd0, key_press}, 32'hA9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
